// File: rtl/fp_add_pkg.sv
// Shared types and widths for the sequential single-precision adder.
package fp_add_pkg;

  localparam int MANT_W    = 23;
  localparam int EXT_W     = 28;
  localparam int EXP_W     = 8;
  localparam int E_SUB_MAX = 28;
  localparam int EXP_MAX   = 255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_PACK  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle: valid-ready on both the operand and result sides.
interface fp_add_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Ovf;
  logic        Zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Result, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Result, Ovf, Zero
  );

endinterface

// File: rtl/fp_add_seq_unit_sel_aug_add.sv
// Picks the larger-magnitude extended mantissa as augend and right-aligns the other.
// Purely combinational; Ce selects the exponent winner, C_mant confirms it on equal exponents.
import fp_add_pkg::*;

module unit_sel_aug_add (
  input  logic [EXT_W-1:0] i_mant_a,
  input  logic [EXT_W-1:0] i_mant_b,
  input  logic             i_ce,
  input  logic [4:0]       i_e_sub,
  output logic [EXT_W-1:0] o_augend,
  output logic [EXT_W-1:0] o_addend,
  output logic             o_c_mant
);

  logic [EXT_W-1:0] w_big;
  logic [EXT_W-1:0] w_small;

  assign w_big    = i_ce ? i_mant_b : i_mant_a;
  assign w_small  = i_ce ? i_mant_a : i_mant_b;
  // A nonzero exponent gap already decides magnitude; only equal exponents need the compare.
  assign o_c_mant = (i_e_sub != 5'd0) || (w_big >= w_small);
  assign o_augend = o_c_mant ? w_big : w_small;
  assign o_addend = (o_c_mant ? w_small : w_big) >> i_e_sub;

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single adder (truncating, flush-to-zero): 4 + NORM cycles per op.
// One operation in flight; operands accepted only in IDLE, result held in DONE until out_ready.
import fp_add_pkg::*;

module fp_add_seq (
  input  logic        clk,
  input  logic        rst,
  fp_add_seq_if.slave bus
);

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_a, r_b;
  logic [EXT_W-1:0]   r_augend, r_addend;
  logic               r_sign, r_eff_sub;
  logic [EXP_W:0]     r_er;
  logic [EXT_W:0]     r_sum;
  logic [4:0]         r_ncnt;
  logic               r_spec, r_spec_ovf;
  logic [31:0]        r_spec_res;
  logic [31:0]        r_result;
  logic               r_ovf, r_zero;

  logic               w_sa, w_sb, w_ce, w_c_mant, w_sign, w_spec, w_spec_ovf, w_norm_exit;
  logic [EXP_W-1:0]   w_ea, w_eb, w_diff, w_er_max;
  logic [4:0]         w_e_sub;
  logic [EXT_W-1:0]   w_ma, w_mb, w_augend, w_addend;
  logic [EXT_W:0]     w_sum_raw;
  logic [31:0]        w_spec_res;

  assign w_sa     = r_a[31];
  assign w_sb     = r_b[31];
  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_ma     = {1'b1, r_a[MANT_W-1:0], {(EXT_W-MANT_W-1){1'b0}}};
  assign w_mb     = {1'b1, r_b[MANT_W-1:0], {(EXT_W-MANT_W-1){1'b0}}};
  assign w_ce     = (w_eb > w_ea);
  assign w_diff   = w_ce ? (w_eb - w_ea) : (w_ea - w_eb);
  assign w_e_sub  = (w_diff > 8'(E_SUB_MAX)) ? 5'(E_SUB_MAX) : w_diff[4:0];
  assign w_er_max = w_ce ? w_eb : w_ea;
  assign w_sign   = w_ce ? (w_c_mant ? w_sb : w_sa) : (w_c_mant ? w_sa : w_sb);

  unit_sel_aug_add u_sel (
    .i_mant_a (w_ma),
    .i_mant_b (w_mb),
    .i_ce     (w_ce),
    .i_e_sub  (w_e_sub),
    .o_augend (w_augend),
    .o_addend (w_addend),
    .o_c_mant (w_c_mant)
  );

  // Infinity outranks zero; a zero operand lets the other through untouched.
  assign w_spec_ovf = (w_ea == 8'(EXP_MAX)) || (w_eb == 8'(EXP_MAX));
  assign w_spec     = w_spec_ovf || (w_ea == 8'd0) || (w_eb == 8'd0);
  assign w_spec_res = (w_ea == 8'(EXP_MAX)) ? {w_sa, 8'hFF, 23'h0} :
                      (w_eb == 8'(EXP_MAX)) ? {w_sb, 8'hFF, 23'h0} :
                      (w_ea == 8'd0)        ? r_b : r_a;

  assign w_sum_raw   = r_eff_sub ? ({1'b0, r_augend} - {1'b0, r_addend})
                                 : ({1'b0, r_augend} + {1'b0, r_addend});
  assign w_norm_exit = (r_sum == '0) || r_sum[EXT_W-1] || (r_ncnt == 5'd27) || (r_er == 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_ALIGN;
      S_ALIGN: w_state_nxt = w_spec ? S_PACK : S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  if (w_norm_exit) w_state_nxt = S_PACK;
      S_PACK:  w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_augend   <= '0;
      r_addend   <= '0;
      r_sign     <= 1'b0;
      r_eff_sub  <= 1'b0;
      r_er       <= '0;
      r_sum      <= '0;
      r_ncnt     <= '0;
      r_spec     <= 1'b0;
      r_spec_ovf <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a <= bus.A;
          r_b <= bus.B;
        end
        S_ALIGN: begin
          r_augend   <= w_augend;
          r_addend   <= w_addend;
          r_sign     <= w_sign;
          r_eff_sub  <= w_sa ^ w_sb;
          r_er       <= {1'b0, w_er_max};
          r_spec     <= w_spec;
          r_spec_ovf <= w_spec_ovf;
          r_spec_res <= w_spec_res;
        end
        S_ADD: begin
          r_ncnt <= 5'd1;
          if (w_sum_raw[EXT_W]) begin
            r_sum <= w_sum_raw >> 1;
            r_er  <= r_er + 9'd1;
          end else begin
            r_sum <= w_sum_raw;
          end
        end
        S_NORM: if (!w_norm_exit) begin
          r_sum  <= r_sum << 1;
          r_er   <= r_er - 9'd1;
          r_ncnt <= r_ncnt + 5'd1;
        end
        S_PACK: begin
          if (r_spec) begin
            r_result <= r_spec_res;
            r_ovf    <= r_spec_ovf;
            r_zero   <= (r_spec_res == 32'h0);
          end else if (r_er >= 9'(EXP_MAX)) begin
            r_result <= {r_sign, 8'hFF, 23'h0};
            r_ovf    <= 1'b1;
            r_zero   <= 1'b0;
          end else if ((r_er == 9'd0) || !r_sum[EXT_W-1]) begin
            r_result <= 32'h0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
          end else begin
            r_result <= {r_sign, r_er[EXP_W-1:0], r_sum[EXT_W-2:EXT_W-1-MANT_W]};
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.Result    = r_result;
  assign bus.Ovf       = r_ovf;
  assign bus.Zero      = r_zero;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq: result, flags, latency, backpressure and mid-op reset.
module tb_fp_add_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fp_add_seq_if bus ();

  fp_add_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Issues one operand pair and checks result, flags and acceptance-to-out_valid latency.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic zero,
                        input int lat, input bit hold);
    int cyc;
    bit seen;
    bus.out_ready = !hold;
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      cyc++;
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, bus.Result, res);
    check({tag, " ovf"}, 32'(bus.Ovf), 32'(ovf));
    check({tag, " zero"}, 32'(bus.Zero), 32'(zero));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " hold result"}, bus.Result, res);
        check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " in_ready after"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bit ever_valid;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst result", bus.Result, 32'h0);
    check("rst ovf", 32'(bus.Ovf), 32'd0);
    check("rst zero", 32'(bus.Zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("1+1",       32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5,  1'b0);
    run_op("1-1",       32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b1, 5,  1'b0);
    run_op("esub sat",  32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0, 5,  1'b0);
    run_op("max+max",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 5,  1'b0);
    run_op("3-2 hold",  32'h40400000, 32'hC0000000, 32'h3F800000, 1'b0, 1'b0, 6,  1'b1);
    run_op("1.5+.25",   32'h3FC00000, 32'h3E800000, 32'h3FE00000, 1'b0, 1'b0, 5,  1'b0);
    run_op("1-4",       32'h3F800000, 32'hC0800000, 32'hC0400000, 1'b0, 1'b0, 6,  1'b0);
    run_op("0+(-5)",    32'h00000000, 32'hC0A00000, 32'hC0A00000, 1'b0, 1'b0, 3,  1'b0);
    run_op("-inf+1",    32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1, 1'b0, 3,  1'b0);
    run_op("long norm", 32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 1'b0, 1'b0, 29, 1'b0);

    // Same long-normalising pair again, cut short by reset while in NORM.
    @(negedge clk);
    bus.A        = 32'h3F800000;
    bus.B        = 32'hBF7FFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid-op busy", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async in_ready", 32'(bus.in_ready), 32'd1);
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("post-rst result", bus.Result, 32'h0);
    check("post-rst ovf", 32'(bus.Ovf), 32'd0);
    ever_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ever_valid = 1'b1;
    end
    check("discarded op", 32'(ever_valid), 32'd0);
    check("idle in_ready", 32'(bus.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
